// File: rtl/addr_mem_if.sv
// Request/response bus between the address path (master) and the memory responder (slave).
// Handshake: a request is accepted on a rising edge where req & ready; ack pulses once per accepted request, with err/rdata valid alongside it.
interface addr_mem_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, ack, err, rdata
  );
endinterface

// File: rtl/addr_mem_responder.sv
// Word memory that serves one read or write per request after a fixed LAT-cycle latency,
// flagging addresses at or beyond DEPTH as out of range.
module addr_mem_responder #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  addr_mem_if.slave  bus,
  output logic [1:0] state_dbg
);

  if (LAT < 1) begin : g_bad_lat
    $error("addr_mem_responder: LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int            CW       = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT >= 2) ? (LAT - 2) : 0);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ack_q, err_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          accept;
  logic          enter_resp;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          in_range;

  logic [DW-1:0] mem [DEPTH];

  assign accept     = (state_q == IDLE) && ready_q && bus.req;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With LAT=1 the commit edge is also the acceptance edge, so the live bus is used.
  assign c_we     = (state_q == IDLE) ? bus.we    : we_q;
  assign c_addr   = (state_q == IDLE) ? bus.addr  : addr_q;
  assign c_wdata  = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign in_range = ({1'b0, c_addr} < DEPTH_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      ack_q   <= enter_resp;
      err_q   <= enter_resp && !in_range;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (enter_resp && !c_we) begin
        rdata_q <= in_range ? mem[c_addr] : '0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && c_we && in_range) begin
      mem[c_addr] <= c_wdata;
    end
  end

  assign bus.ready = ready_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_addr_mem_responder.sv
// Bench for addr_mem_responder: DUT A (DEPTH=200, LAT=2) and DUT B (DEPTH=256, LAT=1).
module tb_addr_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_a, dbg_b;

  addr_mem_if #(.AW(8), .DW(8)) bus_a ();
  addr_mem_if #(.AW(8), .DW(8)) bus_b ();

  addr_mem_responder #(.AW(8), .DW(8), .DEPTH(200), .LAT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(dbg_a)
  );
  addr_mem_responder #(.AW(8), .DW(8), .DEPTH(256), .LAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(dbg_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: plain word arrays per DUT
  int         depth_m [2] = '{200, 256};
  int         lat_m   [2] = '{2, 1};
  logic [7:0] mem_m   [2][256];
  bit         vld_m   [2][256];
  logic [7:0] rd_m    [2];
  bit         rdk_m   [2];

  typedef struct {
    int         d;
    logic       w;
    logic [7:0] a;
    logic [7:0] wd;
    logic       e;
    logic [7:0] rd;
  } vec_t;

  vec_t       tbl [19];
  logic [7:0] exp_q [$];
  logic [7:0] t3_addr [4] = '{8'h10, 8'hC7, 8'h20, 8'h00};
  logic [7:0] t3_data [4] = '{8'hA5, 8'h77, 8'h11, 8'h00};

  int         lat, nacc, nack, last_ack, cnt;
  logic       e, exp_e, rw;
  logic [7:0] rd, ra, rwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic r, input logic w, input logic [7:0] a, input logic [7:0] wd);
    if (d == 0) begin
      bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = wd;
    end else begin
      bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus_a.ready : bus_b.ready;
  endfunction
  function automatic logic get_ack(input int d);
    return (d == 0) ? bus_a.ack : bus_b.ack;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? bus_a.err : bus_b.err;
  endfunction
  function automatic logic [7:0] get_rdata(input int d);
    return (d == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  task automatic wait_ready(input int d);
    int w = 0;
    @(negedge clk);
    while (!get_ready(d) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!get_ready(d)) chk("ready_timeout", 0, 1);
  endtask

  // One access: present for one accepted edge, scramble inputs afterwards, wait for ack.
  task automatic access(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                        output int l, output logic er, output logic [7:0] rdv);
    l = -1; er = 1'b0; rdv = '0;
    wait_ready(d);
    set_in(d, 1'b1, w, a, wd);
    @(negedge clk);
    set_in(d, 1'b0, ~w, ~a, ~wd);
    chk("ready_drop", get_ready(d), 0);
    for (int c = 1; c <= 8; c++) begin
      if (get_ack(d)) begin
        l = c; er = get_err(d); rdv = get_rdata(d);
        break;
      end
      @(negedge clk);
    end
    if (l < 0) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("ack_pulse", get_ack(d), 0);
    chk("ready_back", get_ready(d), 1);
  endtask

  task automatic model_apply(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                             output logic oe);
    oe = (int'(a) >= depth_m[d]);
    if (w) begin
      if (!oe) begin
        mem_m[d][a] = wd;
        vld_m[d][a] = 1'b1;
      end
    end else if (oe) begin
      rd_m[d] = '0; rdk_m[d] = 1'b1;
    end else begin
      rd_m[d] = mem_m[d][a]; rdk_m[d] = vld_m[d][a];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rd_m[d] = '0; rdk_m[d] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    model_reset();

    tbl[0]  = '{0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5};
    tbl[2]  = '{0, 1'b1, 8'hC7, 8'h77, 1'b0, 8'hA5};
    tbl[3]  = '{0, 1'b1, 8'hC8, 8'h3C, 1'b1, 8'hA5};
    tbl[4]  = '{0, 1'b0, 8'hC8, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{0, 1'b0, 8'hC7, 8'h00, 1'b0, 8'h77};
    tbl[6]  = '{0, 1'b1, 8'h20, 8'h11, 1'b0, 8'h77};
    tbl[7]  = '{0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h11};
    tbl[8]  = '{0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00};
    tbl[9]  = '{0, 1'b1, 8'hFF, 8'h5A, 1'b1, 8'h00};
    tbl[10] = '{0, 1'b0, 8'hC7, 8'h00, 1'b0, 8'h77};
    tbl[11] = '{0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h77};
    tbl[12] = '{0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[13] = '{1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[14] = '{1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[15] = '{1, 1'b1, 8'hFF, 8'h6B, 1'b0, 8'h00};
    tbl[16] = '{1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h6B};
    tbl[17] = '{1, 1'b1, 8'hC8, 8'hC3, 1'b0, 8'h6B};
    tbl[18] = '{1, 1'b0, 8'hC8, 8'h00, 1'b0, 8'hC3};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready_a", bus_a.ready, 0);
    chk("rst_ack_a",   bus_a.ack,   0);
    chk("rst_err_a",   bus_a.err,   0);
    chk("rst_rdata_a", bus_a.rdata, 0);
    chk("rst_ready_b", bus_b.ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready_early", bus_a.ready, 0);
    @(negedge clk);
    chk("rel_ready_a", bus_a.ready, 1);
    chk("rel_ready_b", bus_b.ready, 1);

    // directed vectors
    for (int i = 0; i < 19; i++) begin
      access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, lat, e, rd);
      chk($sformatf("row%0d_lat", i),   lat, lat_m[tbl[i].d]);
      chk($sformatf("row%0d_err", i),   e,   tbl[i].e);
      chk($sformatf("row%0d_rdata", i), rd,  tbl[i].rd);
      model_apply(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, exp_e);
    end

    // back-to-back reads with req held high
    nacc = 0; nack = 0; last_ack = -100;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus_a.ack) begin
        nack++;
        if (exp_q.size() > 0) chk("t3_rdata", bus_a.rdata, exp_q.pop_front());
        else                  chk("t3_extra_ack", 1, 0);
        if (nack > 1) chk("t3_spacing", cyc - last_ack, 3);
        last_ack = cyc;
      end
      if (bus_a.ready && nacc < 4) begin
        set_in(0, 1'b1, 1'b0, t3_addr[nacc], 8'h00);
        exp_q.push_back(t3_data[nacc]);
        nacc++;
      end else if (bus_a.ready) begin
        bus_a.req = 1'b0;
      end
    end
    set_in(0, 0, 0, 0, 0);
    chk("t3_acks", nack, 4);
    chk("t3_queue_empty", exp_q.size(), 0);

    // asynchronous reset while ack is high
    wait_ready(0);
    set_in(0, 1'b1, 1'b0, 8'hC7, 8'h00);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_ack_pre",   bus_a.ack,   1);
    chk("t1_rdata_pre", bus_a.rdata, 8'h77);
    #2 rst = 1'b1;
    #1;
    chk("t1_ready", bus_a.ready, 0);
    chk("t1_ack",   bus_a.ack,   0);
    chk("t1_err",   bus_a.err,   0);
    chk("t1_rdata", bus_a.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t1_ready_early", bus_a.ready, 0);
    @(negedge clk);
    chk("t1_ready_after", bus_a.ready, 1);

    // abort a write in WAIT
    wait_ready(0);
    set_in(0, 1'b1, 1'b1, 8'h20, 8'hFF);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("t5_ack_in_rst", bus_a.ack, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.ack) cnt++;
    end
    chk("t5_no_ack", cnt, 0);
    access(0, 1'b0, 8'h20, 8'h00, lat, e, rd);
    model_apply(0, 1'b0, 8'h20, 8'h00, exp_e);
    chk("t5_lat",   lat, 2);
    chk("t5_err",   e,   0);
    chk("t5_rdata", rd,  8'h11);

    // random traffic against the model
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 80; k++) begin
        rw  = 1'($urandom_range(0, 1));
        ra  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hC0, 8'hCF))
                                          : 8'($urandom_range(0, 255));
        rwd = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        access(d, rw, ra, rwd, lat, e, rd);
        model_apply(d, rw, ra, rwd, exp_e);
        chk($sformatf("rnd%0d_%0d_lat", d, k), lat, lat_m[d]);
        chk($sformatf("rnd%0d_%0d_err", d, k), e,   exp_e);
        if (rdk_m[d]) chk($sformatf("rnd%0d_%0d_rdata", d, k), rd, rd_m[d]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
